// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Captures operands A/B and an opcode from shared data switches using three
//   asynchronous load buttons. Each button is synchronised and edge-detected
//   into a single-cycle load pulse. Once all three values are loaded, one ALU
//   operation is issued. The sequencer then waits a fixed ALU latency and
//   latches the result and flags into a result register and into a circular
//   history buffer that the display reads.
//
// Parameters
//   WIDTH        operand/result width
//   OP_W         opcode width; opcode = data_in[WIDTH-1 -: OP_W]
//   SYNC_STAGES  flip-flops per button synchroniser (>= 2)
//   ALU_LATENCY  cycles from alu_start to valid alu_res/alu_flags (>= 1)
//   HIST_DEPTH   number of history entries (power of 2, >= 2)
//
// Ports
//   clk, reset_n          clock; synchronous active-low reset
//   data_in               shared data switches
//   btn_a, btn_b, btn_op  asynchronous load buttons
//   operand_a/b, op       registered operands and opcode to the ALU
//   alu_start             one-cycle issue pulse
//   alu_res, alu_flags    ALU result and flags
//   res_out, flags_out    last captured result and flags
//   res_valid             one-cycle pulse following a capture
//   loaded                {op,b,a} loaded mask
//   busy                  high while an operation is in flight
//   overrun               sticky: a load arrived while busy
//   hist_idx              history read index (0 = newest)
//   hist_res, hist_hit    combinational history read; hit when the index is below the number of stored entries
module alu_operand_sequencer #(
  parameter int WIDTH       = 32,
  parameter int OP_W        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ALU_LATENCY = 1,
  parameter int HIST_DEPTH  = 4,
  localparam int IDX_W      = $clog2(HIST_DEPTH),
  localparam int CNT_W      = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             btn_op,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [OP_W-1:0]  op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] res_out,
  output logic [3:0]       flags_out,
  output logic             res_valid,
  output logic [2:0]       loaded,
  output logic             busy,
  output logic             overrun,
  input  logic [IDX_W-1:0] hist_idx,
  output logic [WIDTH-1:0] hist_res,
  output logic             hist_hit
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [OP_W-1:0]  op_reg;
  logic [3:0]       flags_reg;
  logic [2:0]       mask_reg;
  logic             res_valid_reg;
  logic             overrun_reg;
  logic [IDX_W-1:0] wp_reg;
  logic [IDX_W:0]   count_reg;
  logic [WIDTH-1:0] hist_mem [HIST_DEPTH];

  logic [2:0] btn_raw;
  logic [2:0] load_pulse;
  logic       capture;

  assign btn_raw = {btn_op, btn_b, btn_a};

  // One synchroniser plus rising-edge detector per button. The edge detector
  // compares the last synchroniser stage against its previous value, so a
  // held button produces exactly one pulse.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   prev_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync_reg <= '0;
          prev_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw[gi]};
          prev_reg <= sync_reg[SYNC_STAGES-1];
        end
      end

      assign load_pulse[gi] = sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  endgenerate

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Issue happens on the edge after the registered mask becomes full.
  // The wait counter starts at ALU_LATENCY-1, and capture occurs on the edge
  // where it reads zero. This makes alu_start-to-res_valid equal to
  // ALU_LATENCY+1 cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mask_reg == 3'b111) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
        cnt_next   = CNT_W'(ALU_LATENCY - 1);
      end
      ST_WAIT: begin
        if (cnt_reg == '0) state_next = ST_IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign capture = (state_reg == ST_WAIT) && (cnt_reg == '0);

  // Operand capture, result capture, overrun flag and history bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      mask_reg      <= '0;
      res_reg       <= '0;
      flags_reg     <= '0;
      res_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
      wp_reg        <= '0;
      count_reg     <= '0;
    end else begin
      res_valid_reg <= capture;
      if (state_reg == ST_IDLE) begin
        if (load_pulse[0]) a_reg  <= data_in;
        if (load_pulse[1]) b_reg  <= data_in;
        if (load_pulse[2]) op_reg <= data_in[WIDTH-1 -: OP_W];
        mask_reg <= mask_reg | load_pulse;
      end else if (|load_pulse) begin
        // Operands must stay stable while the ALU works, so drop the load and flag it
        overrun_reg <= 1'b1;
      end
      if (capture) begin
        res_reg   <= alu_res;
        flags_reg <= alu_flags;
        mask_reg  <= '0;
        wp_reg    <= wp_reg + 1'b1;
        if (count_reg != (IDX_W+1)'(HIST_DEPTH)) count_reg <= count_reg + 1'b1;
      end
    end
  end

  // History storage. Entries are not reset because reads are gated by the entry count.
  always_ff @(posedge clk) begin
    if (reset_n && capture) hist_mem[wp_reg] <= alu_res;
  end

  logic [IDX_W-1:0] rd_ptr;
  // Natural wrap of the IDX_W-bit pointer gives the modulo-depth addressing
  assign rd_ptr   = wp_reg - 1'b1 - hist_idx;
  assign hist_hit = ({1'b0, hist_idx} < count_reg);
  assign hist_res = hist_hit ? hist_mem[rd_ptr] : '0;

  assign operand_a = a_reg;
  assign operand_b = b_reg;
  assign op        = op_reg;
  assign alu_start = (state_reg == ST_ISSUE);
  assign busy      = (state_reg != ST_IDLE);
  assign res_out   = res_reg;
  assign flags_out = flags_reg;
  assign res_valid = res_valid_reg;
  assign loaded    = mask_reg;
  assign overrun   = overrun_reg;

endmodule
